// File: rtl/cw_div_multi.sv
// cw_div_multi: multi-channel integer clock divider with near-50% duty output,
// period-start strobe, global enable, synchronous phase alignment and
// divisor changes that only take effect at period boundaries.
module cw_div_multi #(
  parameter int WIDE = 32,
  parameter int CH   = 2
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_En,
  input  logic               i_Sync,
  input  logic [CH*WIDE-1:0] i_Div,
  output logic [CH-1:0]      o_Clk,
  output logic [CH-1:0]      o_Tick
);

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic [WIDE-1:0] div_new;
    logic [WIDE-1:0] div_act_q, div_act_d;
    logic [WIDE-1:0] cnt_q, cnt_d;
    logic            clk_q, clk_d;
    logic            tick_q, tick_d;
    logic [WIDE:0]   div_ext;
    logic [WIDE:0]   half;
    logic [WIDE:0]   cnt_inc;
    logic            wrap;
    logic            act_zero, act_one;

    assign div_new  = i_Div[n*WIDE +: WIDE];
    assign div_ext  = {1'b0, div_act_q};
    // Extra bit keeps (D+1)>>1 and cnt+1 exact at the maximum divisor.
    assign half     = (div_ext + {{WIDE{1'b0}}, 1'b1}) >> 1;
    assign cnt_inc  = {1'b0, cnt_q} + {{WIDE{1'b0}}, 1'b1};
    assign wrap     = (cnt_inc == div_ext);
    assign act_zero = (div_act_q == '0);
    assign act_one  = (div_act_q == WIDE'(1));

    // Next-state: sync restart first, then enabled counting per divisor mode.
    always_comb begin
      div_act_d = div_act_q;
      cnt_d     = cnt_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      if (i_Sync) begin
        div_act_d = div_new;
        cnt_d     = '0;
        clk_d     = (div_new >= WIDE'(2));
        tick_d    = (div_new != '0);
      end else if (i_En) begin
        if (act_zero) begin
          div_act_d = div_new;
          cnt_d     = (div_new == '0) ? '0 : div_new - WIDE'(1);
          clk_d     = 1'b0;
        end else if (act_one) begin
          div_act_d = div_new;
          cnt_d     = '0;
          clk_d     = (div_new >= WIDE'(2));
          tick_d    = (div_new >= WIDE'(2));
        end else if (wrap) begin
          div_act_d = div_new;
          cnt_d     = '0;
          clk_d     = 1'b1;
          tick_d    = 1'b1;
        end else begin
          cnt_d     = cnt_inc[WIDE-1:0];
          clk_d     = (cnt_inc < half);
        end
      end
    end

    // State register; reset preloads cnt so the first enabled edge wraps.
    always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
        div_act_q <= div_new;
        cnt_q     <= (div_new == '0) ? '0 : div_new - WIDE'(1);
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        div_act_q <= div_act_d;
        cnt_q     <= cnt_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
      end
    end

    // Divide-by-one passes the gated input clock through; zero stops the channel.
    assign o_Clk[n]  = act_one ? (i_Clk & i_En) : (!act_zero && clk_q);
    assign o_Tick[n] = act_one ? i_En : (!act_zero && tick_q);
  end

endmodule

// File: tb/tb_cw_div_multi.sv
// tb_cw_div_multi: directed scoreboard bench for cw_div_multi (2 channels).
module tb_cw_div_multi;

  localparam int WIDE = 32;
  localparam int CH   = 2;

  typedef struct packed {
    logic clk;
    logic tick;
  } exp_t;

  logic               i_Clk;
  logic               i_Rst_n;
  logic               i_En;
  logic               i_Sync;
  logic [CH*WIDE-1:0] i_Div;
  logic [CH-1:0]      o_Clk;
  logic [CH-1:0]      o_Tick;

  exp_t q0[$];
  exp_t q1[$];
  int   vectors;
  int   miscompares;
  int   cycle;

  cw_div_multi #(.WIDE(WIDE), .CH(CH)) dut (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_En   (i_En),
    .i_Sync (i_Sync),
    .i_Div  (i_Div),
    .o_Clk  (o_Clk),
    .o_Tick (o_Tick)
  );

  // Free-running system clock, rising edges at 5, 15, 25 ...
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  task automatic applyStimulus(input logic rst_n, input logic en, input logic sync,
                               input logic [WIDE-1:0] div0, input logic [WIDE-1:0] div1);
    i_Rst_n = rst_n;
    i_En    = en;
    i_Sync  = sync;
    i_Div   = {div1, div0};
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cycle, obs, expv);
    end
  endtask

  task automatic pushEntry(input int ch, input logic clk, input logic tick);
    exp_t e;
    e.clk  = clk;
    e.tick = tick;
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected waveform for n whole periods of divisor d: ceil(d/2) high, tick on first.
  task automatic pushPeriod(input int ch, input int d, input int n);
    for (int p = 0; p < n; p++)
      for (int k = 0; k < d; k++)
        pushEntry(ch, (k < (d + 1) / 2), (k == 0));
  endtask

  // One rising edge, then pop and compare whatever each channel expects.
  task automatic stepCycle(input string tag);
    exp_t e;
    @(posedge i_Clk);
    #1;
    cycle++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checkOutput({tag, " clk0"}, o_Clk[0], e.clk);
      checkOutput({tag, " tick0"}, o_Tick[0], e.tick);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput({tag, " clk1"}, o_Clk[1], e.clk);
      checkOutput({tag, " tick1"}, o_Tick[1], e.tick);
    end
  endtask

  task automatic runCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) stepCycle(tag);
  endtask

  task automatic drain(input string tag);
    while (q0.size() > 0 || q1.size() > 0) stepCycle(tag);
  endtask

  // Mid-low-phase check of channel 0 for the combinational pass-through.
  task automatic checkLowPhase(input string tag, input logic clk, input logic tick);
    @(negedge i_Clk);
    #1;
    checkOutput({tag, " clk0 low-phase"}, o_Clk[0], clk);
    checkOutput({tag, " tick0 low-phase"}, o_Tick[0], tick);
  endtask

  // Directed sequence of test steps.
  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;

    // Reset for 3 cycles, then divide by 4 and 6 from the same start.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd4, 32'd6);
    for (int i = 0; i < 3; i++) begin
      pushEntry(0, 1'b0, 1'b0);
      pushEntry(1, 1'b0, 1'b0);
    end
    drain("reset");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd4, 32'd6);
    pushPeriod(0, 4, 3);
    pushPeriod(1, 6, 2);
    drain("div4_div6");

    // Odd divisor 5 over 10 periods: 3 high, 2 low.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd5, 32'd6);
    pushPeriod(0, 5, 10);
    drain("div5");

    // Divisor change mid-period only applies after the current period.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd4, 32'd6);
    pushPeriod(0, 4, 1);
    pushPeriod(0, 7, 2);
    runCycles("div4_to_7", 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd7, 32'd6);
    drain("div4_to_7");

    // Divide by one: output tracks i_Clk, tick constantly high.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1, 32'd6);
    for (int i = 0; i < 4; i++) begin
      pushEntry(0, 1'b1, 1'b1);
      stepCycle("div1");
      checkLowPhase("div1", 1'b0, 1'b1);
    end

    // Divide by zero: channel stopped.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'd6);
    for (int i = 0; i < 3; i++) begin
      pushEntry(0, 1'b0, 1'b0);
      stepCycle("div0");
      checkLowPhase("div0", 1'b0, 1'b0);
    end

    // Load 3 from stopped: load edge quiet, then period starts with tick.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd3, 32'd6);
    pushEntry(0, 1'b0, 1'b0);
    pushPeriod(0, 3, 2);
    drain("div0_to_3");

    // Both channels to 8 at different times, then align with a sync pulse.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd8, 32'd8);
    runCycles("pre_sync", 20);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd8, 32'd8);
    pushPeriod(0, 8, 3);
    pushPeriod(1, 8, 3);
    stepCycle("sync");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd8, 32'd8);
    drain("sync");

    // Enable low for 5 cycles inside a divide-by-6 period.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd6, 32'd8);
    pushEntry(0, 1'b1, 1'b1);
    pushEntry(0, 1'b1, 1'b0);
    drain("en_pre");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd6, 32'd8);
    for (int i = 0; i < 5; i++) pushEntry(0, 1'b1, 1'b0);
    drain("en_low");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd6, 32'd8);
    pushEntry(0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pushEntry(0, 1'b0, 1'b0);
    pushEntry(0, 1'b1, 1'b1);
    pushEntry(0, 1'b1, 1'b0);
    drain("en_resume");

    // Reset in the middle of a high phase drops everything next cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd6, 32'd8);
    for (int i = 0; i < 2; i++) begin
      pushEntry(0, 1'b0, 1'b0);
      pushEntry(1, 1'b0, 1'b0);
    end
    drain("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
